// File: rtl/rgbled_rx.sv
// rgbled_rx: one-wire NRZ RGB LED protocol receiver.
// Samples an asynchronous serial line and classifies each high pulse as a 0 or 1 bit.
// Bits are assembled into 24-bit GRB words, with the first bit received at [23].
// Detects the inter-frame latch gap and flags glitch, stuck-high and partial-word errors.
//
// Ports:
//   clk_sys_i    system clock
//   rst_sys_ni   asynchronous active-low reset
//   din_i        serial line, asynchronous to clk_sys_i
//   clr_i        single-cycle clear of the sticky flags
//   data_o       decoded word (first bit at [23])
//   valid_o      data_o holds an unconsumed word
//   ready_i      consumer accepts the word
//   latch_o      one-cycle pulse when a latch gap is detected
//   overflow_o   sticky, a completed word was dropped
//   error_o      sticky, glitch / stuck-high / partial-word event
//   word_count_o completed words since the last latch (present only with the macro)
//
// Optional feature macro: RGBLED_RX_WORD_COUNT_EN adds word_count_o.
module rgbled_rx #(
  parameter int unsigned SysClkFreq      = 40_000_000,
  // Rounded divisions: the divisors are themselves rounded pulse periods.
  parameter int unsigned BitThreshCycles = (SysClkFreq + 833_333) / 1_666_667,
  parameter int unsigned MinHighCycles   = (SysClkFreq + 3_333_333) / 6_666_667,
  parameter int unsigned MaxHighCycles   = (SysClkFreq + 333_333) / 666_667,
  parameter int unsigned LatchCycles     = (SysClkFreq + 10_000) / 20_000
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        din_i,
  input  logic        clr_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        latch_o,
  output logic        overflow_o,
  output logic        error_o
`ifdef RGBLED_RX_WORD_COUNT_EN
  ,
  output logic [7:0]  word_count_o
`endif
);

  localparam int unsigned CntW     = $clog2(LatchCycles + 1);
  localparam int unsigned WordBits = 24;

  typedef enum logic [1:0] {
    S_WAIT_LATCH = 2'd0,
    S_IDLE       = 2'd1,
    S_HIGH       = 2'd2
  } state_e;

  state_e                r_state, w_state_n;
  logic [2:0]            r_sync;
  logic [CntW-1:0]       r_cnt, w_cnt_n, w_cnt_inc;
  logic [CntW-1:0]       r_bitcnt, w_bitcnt_n;
  logic [WordBits-2:0]   r_shift, w_shift_n;
  logic [WordBits-1:0]   r_data, w_data_n;
  logic                  r_valid, w_valid_n;
  logic                  r_latch, w_latch_n;
  logic                  r_overflow, w_overflow_n;
  logic                  r_error, w_error_n;
  logic                  w_din_s, w_rise, w_fall, w_bit;
`ifdef RGBLED_RX_WORD_COUNT_EN
  logic                  w_word_done;
`endif

  // Two synchroniser flops, third flop for edge detection
  assign w_din_s = r_sync[1];
  assign w_rise  = r_sync[1] & ~r_sync[2];
  assign w_fall  = ~r_sync[1] & r_sync[2];

  // Shared run-length counter saturates at LatchCycles
  assign w_cnt_inc = (r_cnt == CntW'(LatchCycles)) ? r_cnt : r_cnt + CntW'(1);

  // Next-state, decode and flag logic
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_bitcnt_n   = r_bitcnt;
    w_shift_n    = r_shift;
    w_data_n     = r_data;
    w_valid_n    = r_valid;
    w_latch_n    = 1'b0;
    w_overflow_n = clr_i ? 1'b0 : r_overflow;
    w_error_n    = clr_i ? 1'b0 : r_error;
    w_bit        = 1'b0;
`ifdef RGBLED_RX_WORD_COUNT_EN
    w_word_done  = 1'b0;
`endif

    if (r_valid && ready_i) w_valid_n = 1'b0;

    unique case (r_state)
      S_WAIT_LATCH: begin
        if (w_din_s) begin
          w_cnt_n = '0;
        end else begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc == CntW'(LatchCycles)) begin
            w_latch_n  = 1'b1;
            w_bitcnt_n = '0;
            w_state_n  = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (w_rise) begin
          w_cnt_n   = CntW'(1);
          w_state_n = S_HIGH;
        end else if (!w_din_s) begin
          w_cnt_n = w_cnt_inc;
          // Pulse only on the cycle the count first reaches the gap length
          if (r_cnt != CntW'(LatchCycles) && w_cnt_inc == CntW'(LatchCycles)) begin
            w_latch_n = 1'b1;
            if (r_bitcnt != '0) begin
              w_error_n  = 1'b1;
              w_bitcnt_n = '0;
            end
          end
        end
      end

      S_HIGH: begin
        if (w_fall) begin
          w_cnt_n = CntW'(1);
          if (r_cnt < CntW'(MinHighCycles)) begin
            w_error_n  = 1'b1;
            w_bitcnt_n = '0;
            w_state_n  = S_WAIT_LATCH;
          end else begin
            w_bit     = (r_cnt >= CntW'(BitThreshCycles));
            w_shift_n = {r_shift[WordBits-3:0], w_bit};
            w_state_n = S_IDLE;
            if (r_bitcnt == CntW'(WordBits - 1)) begin
              w_bitcnt_n = '0;
`ifdef RGBLED_RX_WORD_COUNT_EN
              w_word_done = 1'b1;
`endif
              // Load only if the holding register is free or being consumed now
              if (!r_valid || ready_i) begin
                w_data_n  = {r_shift, w_bit};
                w_valid_n = 1'b1;
              end else begin
                w_overflow_n = 1'b1;
              end
            end else begin
              w_bitcnt_n = r_bitcnt + CntW'(1);
            end
          end
        end else if (w_din_s) begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc > CntW'(MaxHighCycles)) begin
            w_error_n  = 1'b1;
            w_bitcnt_n = '0;
            w_cnt_n    = '0;
            w_state_n  = S_WAIT_LATCH;
          end
        end
      end

      default: begin
        w_state_n = S_WAIT_LATCH;
        w_cnt_n   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_sync     <= '0;
      r_state    <= S_WAIT_LATCH;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_latch    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[1:0], din_i};
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bitcnt   <= w_bitcnt_n;
      r_shift    <= w_shift_n;
      r_data     <= w_data_n;
      r_valid    <= w_valid_n;
      r_latch    <= w_latch_n;
      r_overflow <= w_overflow_n;
      r_error    <= w_error_n;
    end
  end

  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign latch_o    = r_latch;
  assign overflow_o = r_overflow;
  assign error_o    = r_error;

`ifdef RGBLED_RX_WORD_COUNT_EN
  logic [7:0] r_word_count;

  // Completed-word counter, including dropped words, cleared by each latch
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_word_count <= '0;
    end else if (w_latch_n) begin
      r_word_count <= '0;
    end else if (w_word_done && r_word_count != 8'hFF) begin
      r_word_count <= r_word_count + 8'd1;
    end
  end

  assign word_count_o = r_word_count;
`endif

endmodule

// File: tb/tb_rgbled_rx.sv
// tb_rgbled_rx: self-checking bench for rgbled_rx at default parameters (40 MHz).
// Pulse widths are classified by a reference function from the protocol timing rules.
// A monitor records consumed words and latch pulses.
module tb_rgbled_rx;

  localparam int unsigned Latch = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] data_o;
  logic        valid_o, latch_o, overflow_o, error_o;
`ifdef RGBLED_RX_WORD_COUNT_EN
  logic [7:0]  word_count_o;
  logic [7:0]  wc_at_latch = 8'hAA;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          latch_cnt = 0;
  logic [23:0] obs_q[$];

  rgbled_rx dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .din_i      (din),
    .clr_i      (clr),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .latch_o    (latch_o),
    .overflow_o (overflow_o),
    .error_o    (error_o)
`ifdef RGBLED_RX_WORD_COUNT_EN
    ,
    .word_count_o (word_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: words consumed by the handshake and latch pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready) obs_q.push_back(data_o);
      if (latch_o) begin
        latch_cnt++;
`ifdef RGBLED_RX_WORD_COUNT_EN
        wc_at_latch = word_count_o;
`endif
      end
    end
  end

  // Reference: -1 = error pulse, else decoded bit value
  function automatic int classify(input int hi);
    if (hi < 6 || hi > 60) return -1;
    return (hi >= 24) ? 1 : 0;
  endfunction

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word_std(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) pulse(32, 18);
      else      pulse(16, 34);
    end
  endtask

  task automatic send_random_bits(input int n, output logic [23:0] exp);
    exp = '0;
    for (int i = 0; i < n; i++) begin
      int b, hi, lo;
      b  = int'($urandom_range(1, 0));
      hi = (b != 0) ? int'($urandom_range(60, 24)) : int'($urandom_range(23, 6));
      lo = int'($urandom_range(60, 6));
      exp = (exp << 1) | 24'(classify(hi));
      pulse(hi, lo);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (data_o !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h expected 000000", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (latch_o !== 1'b0) begin n_err++; $display("FAIL reset_latch: got %b expected 0", latch_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", error_o); end
    rst_n = 1'b1;
    gap(Latch + 10);
    n_cmp++; if (latch_cnt !== 1) begin n_err++; $display("FAIL reset_first_latch: got %0d expected 1", latch_cnt); end
  endtask

  task automatic test_single_word();
    int l0;
    ready = 1'b1;
    obs_q.delete();
    send_word_std(24'hA53C0F);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== 24'hA53C0F) begin n_err++; $display("FAIL single_data: got %h expected a53c0f", obs_q[0]); end
    end
    l0 = latch_cnt;
    gap(Latch);
    n_cmp++; if (latch_cnt !== l0 + 1) begin n_err++; $display("FAIL single_latch: got %0d expected %0d", latch_cnt, l0 + 1); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL single_error: got %b expected 0", error_o); end
  endtask

  task automatic test_random_frame();
    logic [23:0] exp_q[$];
    logic [23:0] e;
    ready = 1'b1;
    obs_q.delete();
    for (int w = 0; w < 3; w++) begin
      send_random_bits(24, e);
      exp_q.push_back(e);
    end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL frame_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    gap(Latch + 10);
    n_cmp++; if (error_o !== 1'b0 || overflow_o !== 1'b0) begin n_err++; $display("FAIL frame_flags: got err=%b ovf=%b expected 0 0", error_o, overflow_o); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    clr_pulse();
    send_word_std(24'h000001);
    send_word_std(24'hFFFFFF);
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b expected 1", valid_o); end
    n_cmp++; if (data_o !== 24'h000001) begin n_err++; $display("FAIL ovf_data: got %h expected 000001", data_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    clr_pulse();
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow_o); end
    n_cmp++; if (data_o !== 24'h000001) begin n_err++; $display("FAIL ovf_hold: got %h expected 000001", data_o); end
    ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_consume: got %b expected 0", valid_o); end
    gap(Latch + 10);
    obs_q.delete();
  endtask

  task automatic test_threshold();
    int tbl[4] = '{23, 24, 6, 60};
    int off, hi;
    logic [23:0] e;
    int l0;
    ready = 1'b1;
    clr_pulse();
    obs_q.delete();
    off = int'($urandom_range(3, 0));
    e = '0;
    for (int i = 0; i < 24; i++) begin
      hi = tbl[(i + off) % 4];
      e = (e << 1) | 24'(classify(hi));
      pulse(hi, int'($urandom_range(40, 8)));
    end
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL thr_count: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== e) begin n_err++; $display("FAIL thr_data: got %h expected %h", obs_q[0], e); end
    end
    pulse(5, 40);
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL glitch_error: got %b expected 1", error_o); end
    clr_pulse();
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL glitch_clr: got %b expected 0", error_o); end
    obs_q.delete();
    send_word_std(24'h123456);
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL glitch_ignore: got %0d words expected 0", obs_q.size()); end
    l0 = latch_cnt;
    gap(Latch + 10);
    n_cmp++; if (latch_cnt !== l0 + 1) begin n_err++; $display("FAIL glitch_latch: got %0d expected %0d", latch_cnt, l0 + 1); end
    send_word_std(24'h654321);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL resume_count: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== 24'h654321) begin n_err++; $display("FAIL resume_data: got %h expected 654321", obs_q[0]); end
    end
    gap(Latch + 10);
  endtask

  task automatic test_stuck_partial();
    logic [23:0] e;
    int l0;
    ready = 1'b1;
    clr_pulse();
    pulse(61, 40);
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL stuck_error: got %b expected 1", error_o); end
    l0 = latch_cnt;
    gap(Latch + 10);
    n_cmp++; if (latch_cnt !== l0 + 1) begin n_err++; $display("FAIL stuck_latch: got %0d expected %0d", latch_cnt, l0 + 1); end
    clr_pulse();
    obs_q.delete();
    send_random_bits(10, e);
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL partial_pre: got %b expected 0", error_o); end
    l0 = latch_cnt;
    gap(Latch + 10);
    n_cmp++; if (latch_cnt !== l0 + 1) begin n_err++; $display("FAIL partial_latch: got %0d expected %0d", latch_cnt, l0 + 1); end
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL partial_error: got %b expected 1", error_o); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL partial_novalid: got %0d words expected 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_word();
    logic [23:0] e;
    int l0;
    ready = 1'b0;
    send_word_std(24'hABCDEF);
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rmw_held: got %b expected 1", valid_o); end
    send_random_bits(12, e);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (data_o !== 24'h0 || valid_o !== 1'b0) begin n_err++; $display("FAIL rmw_data: got %h/%b expected 000000/0", data_o, valid_o); end
    n_cmp++; if (error_o !== 1'b0 || overflow_o !== 1'b0 || latch_o !== 1'b0) begin n_err++; $display("FAIL rmw_flags: got %b%b%b expected 000", error_o, overflow_o, latch_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    obs_q.delete();
    send_word_std(24'hC0FFEE);
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL rmw_ignore: got %0d words expected 0", obs_q.size()); end
    l0 = latch_cnt;
    gap(Latch + 10);
    n_cmp++; if (latch_cnt !== l0 + 1) begin n_err++; $display("FAIL rmw_latch: got %0d expected %0d", latch_cnt, l0 + 1); end
    send_word_std(24'h5A5A5A);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL rmw_resume_count: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== 24'h5A5A5A) begin n_err++; $display("FAIL rmw_resume_data: got %h expected 5a5a5a", obs_q[0]); end
    end
    gap(Latch + 10);
  endtask

`ifdef RGBLED_RX_WORD_COUNT_EN
  task automatic test_word_count();
    logic [23:0] e;
    ready = 1'b1;
    n_cmp++; if (word_count_o !== 8'd0) begin n_err++; $display("FAIL wc_start: got %0d expected 0", word_count_o); end
    for (int w = 0; w < 3; w++) send_random_bits(24, e);
    n_cmp++; if (word_count_o !== 8'd3) begin n_err++; $display("FAIL wc_three: got %0d expected 3", word_count_o); end
    wc_at_latch = 8'hAA;
    gap(Latch + 10);
    n_cmp++; if (wc_at_latch !== 8'd0) begin n_err++; $display("FAIL wc_latch: got %0d expected 0", wc_at_latch); end
  endtask
`endif

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    test_single_word();
    test_random_frame();
    test_overflow();
    test_threshold();
    test_stuck_partial();
    test_reset_mid_word();
`ifdef RGBLED_RX_WORD_COUNT_EN
    test_word_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgbled_rx.md
# rgbled_rx

One-wire NRZ LED-protocol receiver: the decoding end of the RGB LED serial output driven by `sonata_system` on `rgbled0`. It samples an asynchronous data line in the system clock domain, classifies each high pulse as a 0 or 1 bit, assembles 24-bit GRB words and detects the inter-frame latch (reset) gap. It is used for on-board loopback self-test of the LED driver and as a daisy-chain input monitor. Decoded words are delivered over a valid/ready handshake.

## Interface
- `SysClkFreq`, 40_000_000: system clock frequency in Hz.
- `BitThreshCycles`, SysClkFreq/1_666_667 (24 at 40 MHz): a high pulse of at least this many cycles decodes as 1, otherwise 0 (0.6 us).
- `MinHighCycles`, SysClkFreq/6_666_667 (6): a shorter high pulse is a glitch error (0.15 us).
- `MaxHighCycles`, SysClkFreq/666_667 (60): a longer high pulse is a stuck-high error (1.5 us).
- `LatchCycles`, SysClkFreq/20_000 (2000): continuous low time that marks a latch gap (50 us).

- `clk_sys_i` input 1: system clock.
- `rst_sys_ni` input 1: reset, asynchronous, active-low.
- `din_i` input 1: serial line, asynchronous to `clk_sys_i`.
- `clr_i` input 1: single-cycle pulse that clears sticky flags.
- `data_o` output 24: decoded word. The first received bit is at [23].
- `valid_o` output 1: `data_o` holds an unconsumed word.
- `ready_i` input 1: consumer accepts the word.
- `latch_o` output 1: one-cycle pulse when a latch gap is detected.
- `overflow_o` output 1: sticky; a word was dropped.
- `error_o` output 1: sticky; a glitch, stuck-high or partial-word event occurred.

## Operation
- **Input synchroniser:** `din_i` passes through a 2-flop synchroniser to give `din_s`. Edges are detected against a third flop.
- **WAIT_LATCH** (entered from reset and after any error):
  - Counts consecutive low cycles of `din_s`; the counter saturates at `LatchCycles`.
  - A high level restarts the count.
  - When the count reaches `LatchCycles`, the FSM pulses `latch_o`, clears the bit counter and moves to IDLE.
- **IDLE:**
  - A rising edge moves the FSM to HIGH and sets the high counter to 1.
  - A low run of `LatchCycles` pulses `latch_o`.
  - If the bit counter is non-zero at that moment, the FSM also sets `error_o` and discards the partial word.
- **HIGH:**
  - The high counter increments each cycle while `din_s` is high.
  - If the count exceeds `MaxHighCycles`, the FSM sets `error_o` and moves to WAIT_LATCH.
  - On a falling edge with count < `MinHighCycles`, the FSM sets `error_o`, discards the partial word and moves to WAIT_LATCH.
  - On any other falling edge, the FSM shifts in bit = (count >= `BitThreshCycles`), increments the bit counter and returns to IDLE. IDLE's low counter starts at 1.
- **Word complete** (24th bit):
  - If `valid_o` is 0, or `valid_o` and `ready_i` are both 1 in that cycle, load `data_o` and set `valid_o`.
  - Otherwise, drop the word and set `overflow_o`. The held `data_o` is unchanged.
  - The bit counter wraps to 0. Frames of any number of words are legal.
- **Handshake:**
  - `valid_o` and `ready_i` both high consumes the word.
  - `valid_o` falls the next cycle unless a new word loads in the same cycle.
  - `data_o` is stable while `valid_o` is high and `ready_i` is low.
- **`clr_i`:** clears `overflow_o` and `error_o`. If a new flag event occurs in the same cycle, the set wins.
- **Counter width:** all counters are $clog2(LatchCycles+1) bits and saturate. There is no wrap-around.

## Timing
- **Reset values:** all outputs 0 (`data_o` = 24'h0). FSM in WAIT_LATCH, all counters 0.
- **Edge latency:** a `din_i` edge is seen by the FSM 2 cycles after it reaches the synchroniser input, ±1 cycle of sampling uncertainty.
- **Valid latency:** `valid_o` rises 1 cycle after the FSM registers the falling edge of the 24th bit.
- **Latch latency:** `latch_o` asserts in the cycle the low count reaches `LatchCycles`.
- **Reset mid-frame:** asserting `rst_sys_ni` mid-frame drops the word in progress and any held word. After reset a latch gap is required before decoding resumes.
- **Throughput:** one word per 24 bit periods. A consumer holding `ready_i` high never causes overflow.

## Configuration
- **`RGBLED_RX_WORD_COUNT_EN` defined:** adds output `word_count_o` (8 bits, reset 0).
  - Increments on every completed word, including dropped words, and saturates at 255.
  - Clears to 0 in the cycle `latch_o` pulses.
- **`RGBLED_RX_WORD_COUNT_EN` undefined:** the port and counter do not exist. All other behaviour is identical.

## Test plan
All scenarios use default parameters at 40 MHz.
- **Single word:** 2000-cycle low, then 24'hA5_3C_0F as bits (1: high 32 / low 18, 0: high 16 / low 34), `ready_i` = 1 -> one `valid_o` pulse with `data_o` = 24'hA53C0F. A 2000-cycle low after the word -> `latch_o` pulses and `error_o` = 0.
- **Overflow:** two words 24'h000001 and 24'hFFFFFF with `ready_i` = 0 -> `data_o` stays 24'h000001, `overflow_o` = 1. A `clr_i` pulse -> `overflow_o` = 0.
- **Threshold boundary:** high pulses of 23 and 24 cycles decode as 0 and 1 respectively. A 5-cycle high pulse sets `error_o`. Decoding resumes only after a 2000-cycle low.
- **Stuck high and partial word:** `din_i` held high for 61 cycles -> `error_o` = 1 and the FSM enters WAIT_LATCH. Separately, 10 bits followed by a 2000-cycle low -> `latch_o` pulses, `error_o` = 1, no `valid_o`.
- **Reset mid-word:** `rst_sys_ni` asserted after 12 bits -> all outputs 0 immediately. The next word sent without a preceding latch gap is ignored.
- **Word count** (with `RGBLED_RX_WORD_COUNT_EN` defined): 3 words then a latch gap -> `word_count_o` reads 3, then 0 in the `latch_o` cycle.
